rocc_cmd_issuer: RTL and testbench

Command issuer sitting directly upstream of the ROCC accelerator in the standalone top. Buffers host-side (DPI/testbench) custom-instruction requests in a small queue, drives the ROCC `io_cmd_*` valid/ready channel, limits outstanding response-producing commands, and returns ROCC `io_resp_*` results to the host through a registered response slot. Replaces the free-floating command wires in the standalone top.

---
 rtl/rocc_issuer_pkg.sv | 23 ++
 rtl/rocc_sync_fifo.sv | 69 ++++++
 rtl/rocc_cmd_issuer.sv | 174 +++++++++++++++++
 tb/tb_rocc_cmd_issuer.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rocc_issuer_pkg.sv
// rocc_issuer_pkg
//   Shared types and constants for the ROCC command issuer.
//   ROCC_OPCODE_CUSTOM0 : major opcode carried by every issued instruction
//   rocc_cmd_t          : one queued host command {funct, rd, xd, rs1, rs2}
//   rocc_resp_t         : one ROCC response held for the host {rd, data}
package rocc_issuer_pkg;

   localparam logic [6:0] ROCC_OPCODE_CUSTOM0 = 7'h0B;

   typedef struct packed {
      logic [6:0]  funct;
      logic [4:0]  rd;
      logic        xd;
      logic [63:0] rs1;
      logic [63:0] rs2;
   } rocc_cmd_t;

   typedef struct packed {
      logic [4:0]  rd;
      logic [63:0] data;
   } rocc_resp_t;

endpackage

// File: rtl/rocc_sync_fifo.sv
// rocc_sync_fifo
//   Single-clock FIFO. Read data is the current head, valid while !empty.
//   Full/empty come from equal indices plus a wrap bit, so any DEPTH >= 1 works.
//   Ports:
//     clock, reset (async, active-low)
//     push, din   : write when !full
//     pop,  dout  : remove head when !empty
//     full, empty : status
module rocc_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_idx;
   logic [AW-1:0]    rd_idx;
   logic             wr_wrap;
   logic             rd_wrap;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign empty   = (wr_idx == rd_idx) && (wr_wrap == rd_wrap);
   assign full    = (wr_idx == rd_idx) && (wr_wrap != rd_wrap);
   assign dout    = mem[rd_idx];

   // Storage is cleared on reset so the head (and thus payload outputs) reads 0.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_idx  <= '0;
         rd_idx  <= '0;
         wr_wrap <= 1'b0;
         rd_wrap <= 1'b0;
      end else begin
         if (do_push) begin
            mem[wr_idx] <= din;
            if (wr_idx == LAST) begin
               wr_idx  <= '0;
               wr_wrap <= !wr_wrap;
            end else begin
               wr_idx  <= wr_idx + AW'(1);
            end
         end
         if (do_pop) begin
            if (rd_idx == LAST) begin
               rd_idx  <= '0;
               rd_wrap <= !rd_wrap;
            end else begin
               rd_idx  <= rd_idx + AW'(1);
            end
         end
      end
   end

endmodule

// File: rtl/rocc_cmd_issuer.sv
// rocc_cmd_issuer
//   Queues host custom-instruction requests, issues them on the ROCC io_cmd
//   channel, caps in-flight response-producing (xd=1) commands at MAX_OUT and
//   returns ROCC responses to the host through a one-entry registered slot.
//   Optional feature macro: ROCC_ISSUER_RD_CHECK_EN
//     defined   -> tag FIFO checks response rd order, sticky rd_mismatch
//     undefined -> rd_mismatch tied to 0
//   Ports:
//     clock, reset (async, active-low)
//     host_cmd_*   : host command in (valid/ready + payload)
//     io_cmd_*     : ROCC command out; inst rs1/rs2/xs1/xs2/opcode constant
//     io_resp_*    : ROCC response in
//     host_resp_*  : host response out
//     outstanding  : in-flight xd command count
//     idle         : queue empty, nothing in flight, response slot empty
//     rd_mismatch  : sticky response-order error
import rocc_issuer_pkg::*;

module rocc_cmd_issuer #(
   parameter int CMD_DEPTH = 4,
   parameter int MAX_OUT   = 4
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         host_cmd_valid,
   output logic                         host_cmd_ready,
   input  logic [6:0]                   host_cmd_funct,
   input  logic [4:0]                   host_cmd_rd,
   input  logic                         host_cmd_xd,
   input  logic [63:0]                  host_cmd_rs1,
   input  logic [63:0]                  host_cmd_rs2,
   output logic                         io_cmd_valid,
   input  logic                         io_cmd_ready,
   output logic [6:0]                   io_cmd_bits_inst_funct,
   output logic [4:0]                   io_cmd_bits_inst_rd,
   output logic                         io_cmd_bits_inst_xd,
   output logic [4:0]                   io_cmd_bits_inst_rs1,
   output logic [4:0]                   io_cmd_bits_inst_rs2,
   output logic                         io_cmd_bits_inst_xs1,
   output logic                         io_cmd_bits_inst_xs2,
   output logic [6:0]                   io_cmd_bits_inst_opcode,
   output logic [63:0]                  io_cmd_bits_rs1,
   output logic [63:0]                  io_cmd_bits_rs2,
   input  logic                         io_resp_valid,
   output logic                         io_resp_ready,
   input  logic [4:0]                   io_resp_bits_rd,
   input  logic [63:0]                  io_resp_bits_data,
   output logic                         host_resp_valid,
   input  logic                         host_resp_ready,
   output logic [4:0]                   host_resp_rd,
   output logic [63:0]                  host_resp_data,
   output logic [$clog2(MAX_OUT+1)-1:0] outstanding,
   output logic                         idle,
   output logic                         rd_mismatch
);

   localparam int OW = $clog2(MAX_OUT + 1);

   rocc_cmd_t  host_cmd;
   rocc_cmd_t  head;
   rocc_resp_t slot;
   logic       slot_full;
   logic       q_full;
   logic       q_empty;
   logic       at_limit;
   logic       cmd_issue;
   logic       xd_issue;
   logic       resp_accept;
   logic       host_hs;

   assign host_cmd = '{funct: host_cmd_funct, rd: host_cmd_rd, xd: host_cmd_xd,
                       rs1: host_cmd_rs1, rs2: host_cmd_rs2};

   // ready depends only on queue state, never on io_cmd_ready
   assign host_cmd_ready = !q_full;

   rocc_sync_fifo #(
      .WIDTH ($bits(rocc_cmd_t)),
      .DEPTH (CMD_DEPTH)
   ) u_cmd_q (
      .clock (clock),
      .reset (reset),
      .push  (host_cmd_valid),
      .din   (host_cmd),
      .pop   (cmd_issue),
      .dout  (head),
      .full  (q_full),
      .empty (q_empty)
   );

   assign at_limit     = (outstanding == OW'(MAX_OUT));
   assign io_cmd_valid = !q_empty && !(head.xd && at_limit);
   assign cmd_issue    = io_cmd_valid && io_cmd_ready;
   assign xd_issue     = cmd_issue && head.xd;

   assign io_cmd_bits_inst_funct  = head.funct;
   assign io_cmd_bits_inst_rd     = head.rd;
   assign io_cmd_bits_inst_xd     = head.xd;
   assign io_cmd_bits_inst_rs1    = 5'd1;
   assign io_cmd_bits_inst_rs2    = 5'd2;
   assign io_cmd_bits_inst_xs1    = 1'b1;
   assign io_cmd_bits_inst_xs2    = 1'b1;
   assign io_cmd_bits_inst_opcode = ROCC_OPCODE_CUSTOM0;
   assign io_cmd_bits_rs1         = head.rs1;
   assign io_cmd_bits_rs2         = head.rs2;

   assign io_resp_ready = !slot_full || host_resp_ready;
   assign resp_accept   = io_resp_valid && io_resp_ready;
   assign host_hs       = slot_full && host_resp_ready;

   // Issue and accept in the same cycle cancel; an accept with nothing in
   // flight is spurious and must not underflow.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         outstanding <= '0;
      end else if (xd_issue && !resp_accept) begin
         outstanding <= outstanding + OW'(1);
      end else if (resp_accept && !xd_issue && (outstanding != '0)) begin
         outstanding <= outstanding - OW'(1);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         slot_full <= 1'b0;
         slot      <= '0;
      end else if (resp_accept) begin
         slot_full <= 1'b1;
         slot      <= '{rd: io_resp_bits_rd, data: io_resp_bits_data};
      end else if (host_hs) begin
         slot_full <= 1'b0;
      end
   end

   assign host_resp_valid = slot_full;
   assign host_resp_rd    = slot.rd;
   assign host_resp_data  = slot.data;
   assign idle            = q_empty && (outstanding == '0) && !slot_full;

`ifdef ROCC_ISSUER_RD_CHECK_EN
   logic [4:0] tag_head;
   logic       tag_full;
   logic       tag_empty;
   logic       resp_bad;

   rocc_sync_fifo #(
      .WIDTH (5),
      .DEPTH (MAX_OUT)
   ) u_tag_q (
      .clock (clock),
      .reset (reset),
      .push  (xd_issue && !tag_full),
      .din   (head.rd),
      .pop   (resp_accept),
      .dout  (tag_head),
      .full  (tag_full),
      .empty (tag_empty)
   );

   assign resp_bad = resp_accept &&
                     ((outstanding == '0) || tag_empty || (tag_head != io_resp_bits_rd));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_mismatch <= 1'b0;
      end else if (resp_bad) begin
         rd_mismatch <= 1'b1;
      end
   end
`else
   assign rd_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_rocc_cmd_issuer.sv
module tb_rocc_cmd_issuer;

   localparam int CMD_DEPTH = 4;
   localparam int MAX_OUT   = 4;
`ifdef ROCC_ISSUER_RD_CHECK_EN
   localparam logic RD_CHK = 1'b1;
`else
   localparam logic RD_CHK = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        host_cmd_valid, host_cmd_ready;
   logic [6:0]  host_cmd_funct;
   logic [4:0]  host_cmd_rd;
   logic        host_cmd_xd;
   logic [63:0] host_cmd_rs1, host_cmd_rs2;
   logic        io_cmd_valid, io_cmd_ready;
   logic [6:0]  io_cmd_bits_inst_funct, io_cmd_bits_inst_opcode;
   logic [4:0]  io_cmd_bits_inst_rd, io_cmd_bits_inst_rs1, io_cmd_bits_inst_rs2;
   logic        io_cmd_bits_inst_xd, io_cmd_bits_inst_xs1, io_cmd_bits_inst_xs2;
   logic [63:0] io_cmd_bits_rs1, io_cmd_bits_rs2;
   logic        io_resp_valid, io_resp_ready;
   logic [4:0]  io_resp_bits_rd;
   logic [63:0] io_resp_bits_data;
   logic        host_resp_valid, host_resp_ready;
   logic [4:0]  host_resp_rd;
   logic [63:0] host_resp_data;
   logic [2:0]  outstanding;
   logic        idle, rd_mismatch;

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   rocc_cmd_issuer #(.CMD_DEPTH(CMD_DEPTH), .MAX_OUT(MAX_OUT)) dut (
      .clock(clock), .reset(reset),
      .host_cmd_valid(host_cmd_valid), .host_cmd_ready(host_cmd_ready),
      .host_cmd_funct(host_cmd_funct), .host_cmd_rd(host_cmd_rd), .host_cmd_xd(host_cmd_xd),
      .host_cmd_rs1(host_cmd_rs1), .host_cmd_rs2(host_cmd_rs2),
      .io_cmd_valid(io_cmd_valid), .io_cmd_ready(io_cmd_ready),
      .io_cmd_bits_inst_funct(io_cmd_bits_inst_funct), .io_cmd_bits_inst_rd(io_cmd_bits_inst_rd),
      .io_cmd_bits_inst_xd(io_cmd_bits_inst_xd), .io_cmd_bits_inst_rs1(io_cmd_bits_inst_rs1),
      .io_cmd_bits_inst_rs2(io_cmd_bits_inst_rs2), .io_cmd_bits_inst_xs1(io_cmd_bits_inst_xs1),
      .io_cmd_bits_inst_xs2(io_cmd_bits_inst_xs2), .io_cmd_bits_inst_opcode(io_cmd_bits_inst_opcode),
      .io_cmd_bits_rs1(io_cmd_bits_rs1), .io_cmd_bits_rs2(io_cmd_bits_rs2),
      .io_resp_valid(io_resp_valid), .io_resp_ready(io_resp_ready),
      .io_resp_bits_rd(io_resp_bits_rd), .io_resp_bits_data(io_resp_bits_data),
      .host_resp_valid(host_resp_valid), .host_resp_ready(host_resp_ready),
      .host_resp_rd(host_resp_rd), .host_resp_data(host_resp_data),
      .outstanding(outstanding), .idle(idle), .rd_mismatch(rd_mismatch)
   );

   task automatic clear_inputs();
      host_cmd_valid    = 1'b0;
      host_cmd_funct    = '0;
      host_cmd_rd       = '0;
      host_cmd_xd       = 1'b0;
      host_cmd_rs1      = '0;
      host_cmd_rs2      = '0;
      io_cmd_ready      = 1'b0;
      io_resp_valid     = 1'b0;
      io_resp_bits_rd   = '0;
      io_resp_bits_data = '0;
      host_resp_ready   = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clock);
      clear_inputs();
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic drive_cmd(input logic [6:0] f, input logic [4:0] rd, input logic xd,
                            input logic [63:0] a, input logic [63:0] b);
      host_cmd_valid = 1'b1;
      host_cmd_funct = f;
      host_cmd_rd    = rd;
      host_cmd_xd    = xd;
      host_cmd_rs1   = a;
      host_cmd_rs2   = b;
   endtask

   task automatic test_reset();
      @(negedge clock);
      clear_inputs();
      reset = 1'b0;
      #1;
      checks++; if (host_cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_host_cmd_ready got=%b exp=1", host_cmd_ready); end
      checks++; if (io_cmd_valid !== 1'b0) begin failures++; $display("FAIL rst_io_cmd_valid got=%b exp=0", io_cmd_valid); end
      checks++; if (io_resp_ready !== 1'b1) begin failures++; $display("FAIL rst_io_resp_ready got=%b exp=1", io_resp_ready); end
      checks++; if (host_resp_valid !== 1'b0) begin failures++; $display("FAIL rst_host_resp_valid got=%b exp=0", host_resp_valid); end
      checks++; if (outstanding !== 3'd0) begin failures++; $display("FAIL rst_outstanding got=%0d exp=0", outstanding); end
      checks++; if (idle !== 1'b1) begin failures++; $display("FAIL rst_idle got=%b exp=1", idle); end
      checks++; if (rd_mismatch !== 1'b0) begin failures++; $display("FAIL rst_rd_mismatch got=%b exp=0", rd_mismatch); end
      checks++; if (io_cmd_bits_rs1 !== 64'd0 || io_cmd_bits_inst_funct !== 7'd0 || host_resp_data !== 64'd0)
         begin failures++; $display("FAIL rst_payload got=%h/%h/%h exp=0", io_cmd_bits_rs1, io_cmd_bits_inst_funct, host_resp_data); end
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic test_single_cmd();
      do_reset();
      drive_cmd(7'd1, 5'd5, 1'b1, 64'h10, 64'h20);
      #1;
      checks++; if (io_cmd_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid got=%b exp=0", io_cmd_valid); end
      @(negedge clock);
      host_cmd_valid = 1'b0;
      #1;
      checks++; if (io_cmd_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", io_cmd_valid); end
      checks++; if (io_cmd_bits_inst_funct !== 7'd1 || io_cmd_bits_inst_rd !== 5'd5 || io_cmd_bits_inst_xd !== 1'b1)
         begin failures++; $display("FAIL single_inst got=%0h/%0h/%b exp=1/5/1", io_cmd_bits_inst_funct, io_cmd_bits_inst_rd, io_cmd_bits_inst_xd); end
      checks++; if (io_cmd_bits_inst_opcode !== 7'h0B || io_cmd_bits_inst_xs1 !== 1'b1 || io_cmd_bits_inst_xs2 !== 1'b1 ||
                    io_cmd_bits_inst_rs1 !== 5'd1 || io_cmd_bits_inst_rs2 !== 5'd2)
         begin failures++; $display("FAIL single_const got=%h/%b/%b/%0d/%0d exp=0b/1/1/1/2", io_cmd_bits_inst_opcode,
                                    io_cmd_bits_inst_xs1, io_cmd_bits_inst_xs2, io_cmd_bits_inst_rs1, io_cmd_bits_inst_rs2); end
      checks++; if (io_cmd_bits_rs1 !== 64'h10 || io_cmd_bits_rs2 !== 64'h20)
         begin failures++; $display("FAIL single_operands got=%h/%h exp=10/20", io_cmd_bits_rs1, io_cmd_bits_rs2); end
      io_cmd_ready = 1'b1;
      @(negedge clock);
      io_cmd_ready = 1'b0;
      #1;
      checks++; if (outstanding !== 3'd1) begin failures++; $display("FAIL single_outstanding got=%0d exp=1", outstanding); end
      checks++; if (io_cmd_valid !== 1'b0 || idle !== 1'b0)
         begin failures++; $display("FAIL single_after got=valid%b idle%b exp=valid0 idle0", io_cmd_valid, idle); end
   endtask

   task automatic test_queue_full();
      do_reset();
      for (int i = 1; i <= 4; i++) begin
         drive_cmd(7'(i), 5'(i), 1'b0, 64'(i), 64'(i));
         #1;
         checks++; if (host_cmd_ready !== 1'b1) begin failures++; $display("FAIL qfull_ready_%0d got=%b exp=1", i, host_cmd_ready); end
         @(negedge clock);
      end
      drive_cmd(7'd5, 5'd5, 1'b0, 64'd5, 64'd5);
      #1;
      checks++; if (host_cmd_ready !== 1'b0) begin failures++; $display("FAIL qfull_ready_low got=%b exp=0", host_cmd_ready); end
      @(negedge clock);
      #1;
      checks++; if (host_cmd_ready !== 1'b0 || io_cmd_bits_inst_funct !== 7'd1)
         begin failures++; $display("FAIL qfull_hold got=rdy%b head%0d exp=rdy0 head1", host_cmd_ready, io_cmd_bits_inst_funct); end
      io_cmd_ready = 1'b1;
      @(negedge clock);
      io_cmd_ready = 1'b0;
      #1;
      checks++; if (host_cmd_ready !== 1'b1 || io_cmd_bits_inst_funct !== 7'd2)
         begin failures++; $display("FAIL qfull_after_pop got=rdy%b head%0d exp=rdy1 head2", host_cmd_ready, io_cmd_bits_inst_funct); end
      @(negedge clock);
      host_cmd_valid = 1'b0;
      io_cmd_ready   = 1'b1;
      for (int i = 2; i <= 5; i++) begin
         #1;
         checks++; if (io_cmd_valid !== 1'b1 || io_cmd_bits_inst_funct !== 7'(i))
            begin failures++; $display("FAIL qfull_drain_%0d got=v%b f%0d exp=v1 f%0d", i, io_cmd_valid, io_cmd_bits_inst_funct, i); end
         @(negedge clock);
      end
      #1;
      checks++; if (idle !== 1'b1) begin failures++; $display("FAIL qfull_idle got=%b exp=1", idle); end
   endtask

   task automatic test_max_out();
      do_reset();
      io_cmd_ready = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         drive_cmd(7'(i), 5'(i == 5 ? 9 : (i == 6 ? 10 : i)), (i != 6), 64'(i), 64'(i));
         @(negedge clock);
      end
      host_cmd_valid = 1'b0;
      @(negedge clock);
      #1;
      checks++; if (outstanding !== 3'd4) begin failures++; $display("FAIL maxout_count got=%0d exp=4", outstanding); end
      checks++; if (io_cmd_valid !== 1'b0 || io_cmd_bits_inst_rd !== 5'd9)
         begin failures++; $display("FAIL maxout_stall got=v%b rd%0d exp=v0 rd9", io_cmd_valid, io_cmd_bits_inst_rd); end
      host_resp_ready = 1'b1;
      io_resp_valid   = 1'b1;
      io_resp_bits_rd = 5'd1;
      @(negedge clock);
      io_resp_valid = 1'b0;
      #1;
      checks++; if (io_cmd_valid !== 1'b1 || io_cmd_bits_inst_rd !== 5'd9 || outstanding !== 3'd3)
         begin failures++; $display("FAIL maxout_release got=v%b rd%0d out%0d exp=v1 rd9 out3", io_cmd_valid, io_cmd_bits_inst_rd, outstanding); end
      @(negedge clock);
      #1;
      checks++; if (io_cmd_valid !== 1'b1 || io_cmd_bits_inst_rd !== 5'd10 || outstanding !== 3'd4)
         begin failures++; $display("FAIL maxout_nonxd got=v%b rd%0d out%0d exp=v1 rd10 out4", io_cmd_valid, io_cmd_bits_inst_rd, outstanding); end
   endtask

   task automatic test_resp_slot();
      do_reset();
      io_resp_valid     = 1'b1;
      io_resp_bits_rd   = 5'd5;
      io_resp_bits_data = 64'hDEAD;
      #1;
      checks++; if (io_resp_ready !== 1'b1) begin failures++; $display("FAIL slot_ready_empty got=%b exp=1", io_resp_ready); end
      @(negedge clock);
      io_resp_bits_rd   = 5'd7;
      io_resp_bits_data = 64'hBEEF;
      #1;
      checks++; if (host_resp_valid !== 1'b1 || host_resp_rd !== 5'd5 || host_resp_data !== 64'hDEAD)
         begin failures++; $display("FAIL slot_load got=v%b rd%0d d%h exp=v1 rd5 dDEAD", host_resp_valid, host_resp_rd, host_resp_data); end
      checks++; if (io_resp_ready !== 1'b0) begin failures++; $display("FAIL slot_ready_full got=%b exp=0", io_resp_ready); end
      checks++; if (outstanding !== 3'd0 || rd_mismatch !== RD_CHK)
         begin failures++; $display("FAIL slot_spurious got=out%0d mis%b exp=out0 mis%b", outstanding, rd_mismatch, RD_CHK); end
      @(negedge clock);
      #1;
      checks++; if (host_resp_data !== 64'hDEAD) begin failures++; $display("FAIL slot_hold got=%h exp=DEAD", host_resp_data); end
      host_resp_ready = 1'b1;
      #1;
      checks++; if (io_resp_ready !== 1'b1) begin failures++; $display("FAIL slot_ready_passthru got=%b exp=1", io_resp_ready); end
      @(negedge clock);
      io_resp_valid = 1'b0;
      #1;
      checks++; if (host_resp_valid !== 1'b1 || host_resp_rd !== 5'd7 || host_resp_data !== 64'hBEEF)
         begin failures++; $display("FAIL slot_reload got=v%b rd%0d d%h exp=v1 rd7 dBEEF", host_resp_valid, host_resp_rd, host_resp_data); end
      @(negedge clock);
      #1;
      checks++; if (host_resp_valid !== 1'b0 || idle !== 1'b1)
         begin failures++; $display("FAIL slot_clear got=v%b idle%b exp=v0 idle1", host_resp_valid, idle); end
   endtask

   task automatic test_same_cycle();
      do_reset();
      io_cmd_ready    = 1'b1;
      host_resp_ready = 1'b1;
      drive_cmd(7'd3, 5'd3, 1'b1, 64'h3, 64'h3);
      @(negedge clock);
      drive_cmd(7'd4, 5'd4, 1'b1, 64'h4, 64'h4);
      @(negedge clock);
      host_cmd_valid  = 1'b0;
      io_resp_valid   = 1'b1;
      io_resp_bits_rd = 5'd3;
      io_resp_bits_data = 64'h33;
      #1;
      checks++; if (io_cmd_valid !== 1'b1 || outstanding !== 3'd1)
         begin failures++; $display("FAIL same_pre got=v%b out%0d exp=v1 out1", io_cmd_valid, outstanding); end
      @(negedge clock);
      io_resp_valid = 1'b0;
      #1;
      checks++; if (outstanding !== 3'd1) begin failures++; $display("FAIL same_count got=%0d exp=1", outstanding); end
      checks++; if (host_resp_valid !== 1'b1 || host_resp_rd !== 5'd3 || rd_mismatch !== 1'b0)
         begin failures++; $display("FAIL same_resp got=v%b rd%0d mis%b exp=v1 rd3 mis0", host_resp_valid, host_resp_rd, rd_mismatch); end
   endtask

`ifdef ROCC_ISSUER_RD_CHECK_EN
   task automatic test_rd_check();
      do_reset();
      io_cmd_ready    = 1'b1;
      host_resp_ready = 1'b1;
      drive_cmd(7'd1, 5'd3, 1'b1, 64'h1, 64'h1);
      @(negedge clock);
      drive_cmd(7'd1, 5'd4, 1'b1, 64'h2, 64'h2);
      @(negedge clock);
      host_cmd_valid = 1'b0;
      @(negedge clock);
      io_resp_valid   = 1'b1;
      io_resp_bits_rd = 5'd4;
      #1;
      checks++; if (outstanding !== 3'd2 || rd_mismatch !== 1'b0)
         begin failures++; $display("FAIL rdchk_pre got=out%0d mis%b exp=out2 mis0", outstanding, rd_mismatch); end
      @(negedge clock);
      io_resp_bits_rd = 5'd3;
      #1;
      checks++; if (rd_mismatch !== 1'b1) begin failures++; $display("FAIL rdchk_set got=%b exp=1", rd_mismatch); end
      @(negedge clock);
      io_resp_valid = 1'b0;
      @(negedge clock);
      #1;
      checks++; if (rd_mismatch !== 1'b1 || outstanding !== 3'd0)
         begin failures++; $display("FAIL rdchk_sticky got=mis%b out%0d exp=mis1 out0", rd_mismatch, outstanding); end
   endtask
`endif

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive_cmd(7'(i + 1), 5'(i + 1), 1'b1, 64'hAA, 64'hBB);
         io_cmd_ready = (i == 0);
         @(negedge clock);
      end
      io_resp_valid     = 1'b1;
      io_resp_bits_rd   = 5'd9;
      io_resp_bits_data = 64'h1234;
      @(negedge clock);
      #2;
      reset = 1'b0;
      #1;
      checks++; if (host_cmd_ready !== 1'b1 || io_cmd_valid !== 1'b0 || io_resp_ready !== 1'b1 || host_resp_valid !== 1'b0)
         begin failures++; $display("FAIL midrst_hs got=%b%b%b%b exp=1010", host_cmd_ready, io_cmd_valid, io_resp_ready, host_resp_valid); end
      checks++; if (outstanding !== 3'd0 || idle !== 1'b1 || rd_mismatch !== 1'b0 || io_cmd_bits_rs1 !== 64'd0 || host_resp_data !== 64'd0)
         begin failures++; $display("FAIL midrst_state got=out%0d idle%b mis%b rs1%h d%h exp=0/1/0/0/0", outstanding, idle, rd_mismatch, io_cmd_bits_rs1, host_resp_data); end
      @(negedge clock);
      clear_inputs();
      reset = 1'b1;
   endtask

   typedef struct {
      logic [6:0]  f;
      logic [4:0]  rd;
      logic        xd;
      logic [63:0] a;
      logic [63:0] b;
   } m_cmd_t;

   task automatic test_random();
      m_cmd_t      mq[$];
      logic [4:0]  mtags[$];
      m_cmd_t      c;
      int          m_out  = 0;
      logic        m_slot = 1'b0;
      logic [4:0]  m_rd   = '0;
      logic [63:0] m_data = '0;
      logic        m_mis  = 1'b0;
      logic        e_hcr, e_icv, e_irr, do_issue, do_acc, issued_xd;
      logic [4:0]  t;
      do_reset();
      for (int cyc = 0; cyc < 400; cyc++) begin
         drive_cmd(7'($urandom), 5'($urandom), 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
         host_cmd_valid    = ($urandom_range(0, 2) != 0);
         io_cmd_ready      = ($urandom_range(0, 3) != 0);
         io_resp_valid     = (m_out > 0) && ($urandom_range(0, 1) == 1);
         io_resp_bits_rd   = (mtags.size() > 0 && $urandom_range(0, 15) != 0) ? mtags[0] : 5'($urandom);
         io_resp_bits_data = {$urandom, $urandom};
         host_resp_ready   = ($urandom_range(0, 2) != 0);
         #1;
         e_hcr = (mq.size() < CMD_DEPTH);
         e_icv = (mq.size() > 0) && !(mq[0].xd && m_out == MAX_OUT);
         e_irr = !m_slot || host_resp_ready;
         checks++; if (host_cmd_ready !== e_hcr) begin failures++; $display("FAIL rnd_host_cmd_ready cyc=%0d got=%b exp=%b", cyc, host_cmd_ready, e_hcr); end
         checks++; if (io_cmd_valid !== e_icv) begin failures++; $display("FAIL rnd_io_cmd_valid cyc=%0d got=%b exp=%b", cyc, io_cmd_valid, e_icv); end
         if (mq.size() > 0) begin
            checks++;
            if (io_cmd_bits_inst_funct !== mq[0].f || io_cmd_bits_inst_rd !== mq[0].rd || io_cmd_bits_inst_xd !== mq[0].xd ||
                io_cmd_bits_rs1 !== mq[0].a || io_cmd_bits_rs2 !== mq[0].b)
               begin failures++; $display("FAIL rnd_payload cyc=%0d got=%h/%h/%b/%h/%h exp=%h/%h/%b/%h/%h", cyc,
                  io_cmd_bits_inst_funct, io_cmd_bits_inst_rd, io_cmd_bits_inst_xd, io_cmd_bits_rs1, io_cmd_bits_rs2,
                  mq[0].f, mq[0].rd, mq[0].xd, mq[0].a, mq[0].b); end
         end
         checks++; if (io_resp_ready !== e_irr) begin failures++; $display("FAIL rnd_io_resp_ready cyc=%0d got=%b exp=%b", cyc, io_resp_ready, e_irr); end
         checks++; if (host_resp_valid !== m_slot) begin failures++; $display("FAIL rnd_host_resp_valid cyc=%0d got=%b exp=%b", cyc, host_resp_valid, m_slot); end
         if (m_slot) begin
            checks++; if (host_resp_rd !== m_rd || host_resp_data !== m_data)
               begin failures++; $display("FAIL rnd_host_resp cyc=%0d got=%h/%h exp=%h/%h", cyc, host_resp_rd, host_resp_data, m_rd, m_data); end
         end
         checks++; if (outstanding !== 3'(m_out)) begin failures++; $display("FAIL rnd_outstanding cyc=%0d got=%0d exp=%0d", cyc, outstanding, m_out); end
         checks++; if (idle !== (mq.size() == 0 && m_out == 0 && !m_slot))
            begin failures++; $display("FAIL rnd_idle cyc=%0d got=%b exp=%b", cyc, idle, (mq.size() == 0 && m_out == 0 && !m_slot)); end
         checks++; if (rd_mismatch !== (RD_CHK & m_mis))
            begin failures++; $display("FAIL rnd_rd_mismatch cyc=%0d got=%b exp=%b", cyc, rd_mismatch, RD_CHK & m_mis); end

         do_issue  = e_icv && io_cmd_ready;
         do_acc    = io_resp_valid && e_irr;
         issued_xd = 1'b0;
         if (do_acc) begin
            t = mtags.pop_front();
            if (t != io_resp_bits_rd) m_mis = 1'b1;
         end
         if (do_issue) begin
            c = mq.pop_front();
            issued_xd = c.xd;
            if (c.xd) mtags.push_back(c.rd);
         end
         if (host_cmd_valid && e_hcr)
            mq.push_back('{f: host_cmd_funct, rd: host_cmd_rd, xd: host_cmd_xd, a: host_cmd_rs1, b: host_cmd_rs2});
         if (issued_xd && !do_acc) m_out++;
         else if (do_acc && !issued_xd && m_out > 0) m_out--;
         if (do_acc) begin
            m_slot = 1'b1;
            m_rd   = io_resp_bits_rd;
            m_data = io_resp_bits_data;
         end else if (m_slot && host_resp_ready) begin
            m_slot = 1'b0;
         end
         @(negedge clock);
      end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_single_cmd();
      test_queue_full();
      test_max_out();
      test_resp_slot();
      test_same_cycle();
`ifdef ROCC_ISSUER_RD_CHECK_EN
      test_rd_check();
`endif
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
